// File: rtl/word_address_counter_pkg.sv
// ---------------------------------------------------------------------------
// word_address_counter_pkg
// Shared definitions for the DMA address / word-count datapath:
//   - default data width
//   - instruction codes, word-count mode codes, transfer state encoding
//   - control register bit positions and counter slot indices
// ---------------------------------------------------------------------------
package word_address_counter_pkg;

    localparam int DEFAULT_DATA_LENGTH = 8;

    typedef enum logic [2:0] {
        INSTR_WCR    = 3'b000,  // write control register
        INSTR_RCR    = 3'b001,  // read control register
        INSTR_RWC    = 3'b010,  // read word counter
        INSTR_RAC    = 3'b011,  // read address counter
        INSTR_REINIT = 3'b100,  // reload counters from registers
        INSTR_LDA    = 3'b101,  // load address
        INSTR_LDWC   = 3'b110,  // load word count
        INSTR_ENC    = 3'b111   // enable counting
    } instr_t;

    typedef enum logic [1:0] {
        MODE_WC_ZERO      = 2'b00,  // word counter decrements towards zero
        MODE_WC_COMPARE   = 2'b01,  // word counter increments, compared externally
        MODE_ADDR_COMPARE = 2'b10,  // word counter holds the stop address
        MODE_CARRY_OUT    = 2'b11   // word counter increments to carry-out
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACTIVE   = 2'b01,
        ST_COMPLETE = 2'b10
    } state_t;

    // Control register layout
    localparam int CTRL_WIDTH    = 3;
    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_MODE_MSB = 1;
    localparam int CTRL_DIR      = 2;

    // Counter slots inside the top-level counter array
    localparam int NUM_COUNTERS = 2;
    localparam int CNT_ADDR     = 0;
    localparam int CNT_WORD     = 1;

endpackage

// File: rtl/word_address_counter_loadable_counter.sv
// ---------------------------------------------------------------------------
// loadable_counter
// Up/down counter with synchronous load. Load has priority over counting.
// Ports:
//   clk, rst    : clock and synchronous active-high reset (count -> 0)
//   load        : load load_value on the next edge
//   load_value  : value to load
//   en          : counting allowed this cycle
//   down        : 1 = subtract step, 0 = add step
//   step        : 1-bit step size (carry-in)
//   count       : current counter contents
// ---------------------------------------------------------------------------
module loadable_counter #(
    parameter int DATA_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [DATA_LENGTH-1:0] load_value,
    input  logic                   en,
    input  logic                   down,
    input  logic                   step,
    output logic [DATA_LENGTH-1:0] count
);

    logic [DATA_LENGTH-1:0] count_reg;
    logic [DATA_LENGTH-1:0] step_ext;

    assign step_ext = {{(DATA_LENGTH-1){1'b0}}, step};

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en) begin
            // Natural modulo-2^N wrap in both directions
            count_reg <= down ? (count_reg - step_ext) : (count_reg + step_ext);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/word_address_counter.sv
// ---------------------------------------------------------------------------
// word_address_counter
// Am2940-style DMA address / word-count datapath. Holds the control register,
// address register/counter and word-count register/counter, executes 3-bit
// instructions and tracks the transfer state (IDLE / ACTIVE / COMPLETE).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   instr          : instruction code
//   data_in        : data bus write value
//   data_out       : data bus read value (combinational, 0 unless reading)
//   data_oe        : high for read instructions RCR/RWC/RAC
//   aci, cinwc     : address / word count carry-in (step enable)
//   done           : transfer complete from external circuitry
//   ctrl_mode      : control register mode bits
//   next_address   : address counter contents
//   next_word_cnt  : word counter contents
//   word_cnt       : word count register contents
//   active         : transfer is active
// Optional (macro CARRY_OUT_EN):
//   aco, wco       : address / word counter carry-out at terminal value
// ---------------------------------------------------------------------------
module word_address_counter
    import word_address_counter_pkg::*;
#(
    parameter int DATA_LENGTH = DEFAULT_DATA_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2:0]             instr,
    input  logic [DATA_LENGTH-1:0] data_in,
    output logic [DATA_LENGTH-1:0] data_out,
    output logic                   data_oe,
    input  logic                   aci,
    input  logic                   cinwc,
    input  logic                   done,
    output logic [1:0]             ctrl_mode,
    output logic [DATA_LENGTH-1:0] next_address,
    output logic [DATA_LENGTH-1:0] next_word_cnt,
    output logic [DATA_LENGTH-1:0] word_cnt,
`ifdef CARRY_OUT_EN
    output logic                   aco,
    output logic                   wco,
`endif
    output logic                   active
);

    logic [CTRL_WIDTH-1:0]  ctrl_reg;
    logic [DATA_LENGTH-1:0] addr_reg;
    logic [DATA_LENGTH-1:0] wc_reg;
    state_t                 state_reg;
    state_t                 state_next;

    mode_t                  mode;
    logic                   dir;
    logic                   count_active;
    logic [DATA_LENGTH-1:0] wc_src;

    logic [NUM_COUNTERS-1:0]                  cnt_load;
    logic [NUM_COUNTERS-1:0][DATA_LENGTH-1:0] cnt_value;
    logic [NUM_COUNTERS-1:0]                  cnt_en;
    logic [NUM_COUNTERS-1:0]                  cnt_down;
    logic [NUM_COUNTERS-1:0]                  cnt_step;
    logic [NUM_COUNTERS-1:0][DATA_LENGTH-1:0] cnt_q;

    assign mode = mode_t'(ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB]);
    assign dir  = ctrl_reg[CTRL_DIR];

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg <= '0;
            addr_reg <= '0;
            wc_reg   <= '0;
        end else begin
            if (instr == INSTR_WCR) begin
                ctrl_reg <= data_in[CTRL_WIDTH-1:0];
            end
            if (instr == INSTR_LDA) begin
                addr_reg <= data_in;
            end
            if (instr == INSTR_LDWC) begin
                wc_reg <= data_in;
            end
        end
    end

    // ---------------- transfer state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (instr)
            INSTR_REINIT,
            INSTR_LDWC: state_next = ST_ACTIVE;
            INSTR_ENC: begin
                // done only matters while actively counting
                if (state_reg == ST_ACTIVE && done) begin
                    state_next = ST_COMPLETE;
                end
            end
            default: state_next = state_reg;
        endcase
    end

    // ---------------- counter control ----------------
    // The completing ENC edge still counts: gating uses the current state.
    assign count_active = (instr == INSTR_ENC) && (state_reg == ST_ACTIVE);

    always_comb begin
        cnt_load  = '0;
        cnt_value = '0;
        cnt_en    = '0;
        cnt_down  = '0;
        cnt_step  = '0;

        cnt_load[CNT_ADDR]  = (instr == INSTR_LDA) || (instr == INSTR_REINIT);
        cnt_value[CNT_ADDR] = (instr == INSTR_LDA) ? data_in : addr_reg;
        cnt_en[CNT_ADDR]    = count_active;
        cnt_down[CNT_ADDR]  = dir;
        cnt_step[CNT_ADDR]  = aci;

        // Up-counting modes start from zero; the other modes load the count
        wc_src              = (instr == INSTR_LDWC) ? data_in : wc_reg;
        cnt_load[CNT_WORD]  = (instr == INSTR_LDWC) || (instr == INSTR_REINIT);
        cnt_value[CNT_WORD] = (mode == MODE_WC_ZERO || mode == MODE_ADDR_COMPARE)
                              ? wc_src : '0;
        cnt_en[CNT_WORD]    = count_active && (mode != MODE_ADDR_COMPARE);
        cnt_down[CNT_WORD]  = (mode == MODE_WC_ZERO);
        cnt_step[CNT_WORD]  = cinwc;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_COUNTERS; gi++) begin : g_counter
            loadable_counter #(
                .DATA_LENGTH (DATA_LENGTH)
            ) u_counter (
                .clk        (clk),
                .rst        (rst),
                .load       (cnt_load[gi]),
                .load_value (cnt_value[gi]),
                .en         (cnt_en[gi]),
                .down       (cnt_down[gi]),
                .step       (cnt_step[gi]),
                .count      (cnt_q[gi])
            );
        end
    endgenerate

    // ---------------- read path ----------------
    always_comb begin
        data_out = '0;
        data_oe  = 1'b0;
        if (!rst) begin
            case (instr)
                INSTR_RCR: begin
                    data_out = {{(DATA_LENGTH-CTRL_WIDTH){1'b0}}, ctrl_reg};
                    data_oe  = 1'b1;
                end
                INSTR_RWC: begin
                    data_out = cnt_q[CNT_WORD];
                    data_oe  = 1'b1;
                end
                INSTR_RAC: begin
                    data_out = cnt_q[CNT_ADDR];
                    data_oe  = 1'b1;
                end
                default: begin
                    data_out = '0;
                    data_oe  = 1'b0;
                end
            endcase
        end
    end

`ifdef CARRY_OUT_EN
    always_comb begin
        aco = 1'b0;
        wco = 1'b0;
        if (!rst) begin
            aco = aci & (dir ? (cnt_q[CNT_ADDR] == '0) : (&cnt_q[CNT_ADDR]));
            case (mode)
                MODE_WC_ZERO:      wco = cinwc & (cnt_q[CNT_WORD] == '0);
                MODE_ADDR_COMPARE: wco = 1'b0;
                default:           wco = cinwc & (&cnt_q[CNT_WORD]);
            endcase
        end
    end
`endif

    assign ctrl_mode     = ctrl_reg[CTRL_MODE_MSB:CTRL_MODE_LSB];
    assign next_address  = cnt_q[CNT_ADDR];
    assign next_word_cnt = cnt_q[CNT_WORD];
    assign word_cnt      = wc_reg;
    assign active        = (state_reg == ST_ACTIVE);

endmodule
